mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the on-chip 32K×16 program/data RAM. Port 0 serves the CPU memory path and port 1 a secondary master such as a DMA or boot loader. The block grants one request at a time, drives the RAM address, write-data and write-enable, and handles the RAM's one-cycle read latency. Each requester receives a one-cycle acknowledge and, for reads, registered read data.

## Interface
- ADDR_W, 15: RAM word-address width.
- DATA_W, 16: data width.

- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from port 0 / port 1; held until that port's ack.
- we0 / we1  input  1  1 = write, 0 = read; held with req.
- addr0 / addr1  input  ADDR_W  word address; held with req.
- wdata0 / wdata1  input  DATA_W  write data; held with req.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  DATA_W  read data, valid when ack is high; held until that port's next read completes.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_rdata  input  DATA_W  RAM read data, valid one cycle after address.
- busy  output  1  high whenever state is not IDLE.
- owner  output  1  port owning the current or last transaction.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, ACK. Encoding is 2-bit binary.
- IDLE:
  - If req0|req1, select the winner and latch its we/addr/wdata into ram_we/ram_addr/ram_wdata.
  - Set owner to the winner and go to ISSUE; otherwise stay in IDLE.
- ISSUE:
  - RAM sees the registered address and we for exactly this cycle.
  - Clear ram_we at the end of the cycle.
  - Go to ACK if the transaction is a write, RD_WAIT if it is a read.
- RD_WAIT:
  - ram_rdata is valid in this cycle.
  - Capture it into rdata[owner] at the end of the cycle and go to ACK.
- ACK:
  - Assert ack[owner] for this cycle only, then go to IDLE.
- Requester rules:
  - A requester must drop or renew req in the cycle after ack.
  - If req is still high when IDLE samples it, it is treated as a new request.
- Requests are sampled only in IDLE. Changes to a request's signals after it is granted are ignored.
- If req is dropped mid-transaction, the transaction still completes and ack still pulses.
- rdata of the non-owner port never changes. A write never changes any rdata.
- ram_addr and ram_wdata hold their last values outside ISSUE. Only ram_we is qualified to the ISSUE cycle.
- Simultaneous req0 and req1 in IDLE: the winner is chosen per Configuration. The loser stays pending and is served in the next IDLE if its req is still held.

## Timing
- Reset values: state IDLE; ack0, ack1, ram_we, busy, owner = 0; ram_addr, ram_wdata, rdata0, rdata1 = 0.
- Reset takes effect asynchronously, including mid-transaction. ram_we drops immediately and no ack is issued for an aborted transaction.
- Write latency: req sampled in IDLE at edge t; ISSUE in cycle t+1; ack high in cycle t+2.
- Read latency: ack and rdata valid in cycle t+3.
- Peak throughput: one write per 3 cycles, one read per 4 cycles.
- busy rises in the cycle after a grant and falls in the cycle after ACK.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A last-grant register is initialised to 1 on reset, so port 0 wins the first contention.
  - On contention, the port not granted last wins.
  - A single requester is always granted regardless of history.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; port 0 always wins contention.
  - The last-grant register is not implemented.

## Structure
- Shared package mem_arb_pkg holds:
  - FSM state constants IDLE, ISSUE, RD_WAIT, ACK.
  - Default widths ADDR_W=15 and DATA_W=16.
- Sub-module arb_select2 performs winner selection.
  - Inputs: req0, req1, last.
  - Outputs: gnt, valid.
  - It is combinational and holds the round-robin/fixed-priority macro logic.
- The FSM and datapath registers stay in mem_arbiter.

## Test plan
- Reset mid-read: assert reset_n=0 during RD_WAIT -> ram_we=0 and state IDLE immediately; no ack; rdata0 unchanged.
- Single write then read: port 0 writes addr 0x0010, data 0xBEEF -> ram_we high only in ISSUE, ack0 at t+2. Port 0 then reads 0x0010 -> ack0 at t+3 with rdata0=0xBEEF.
- Contention, round-robin: req0 and req1 held continuously, both reads -> grants alternate 0,1,0,1; acks 4 cycles apart; rdata1 never changes on port-0 acks.
- Contention, fixed priority (macro undefined): req0 re-asserted in the cycle after every ack0, req1 held continuously -> ack1 only once req0 stays low for an IDLE sample.
- Request drop: port 1 deasserts req1 during ISSUE of a write -> write to RAM still occurs and ack1 still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared FSM state encoding and default widths for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    RD_WAIT = 2'b10,
    ACK     = 2'b11
  } state_t;

endpackage

// File: rtl/arb_select2.sv
// Combinational winner select for two requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module arb_select2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic valid
);

  assign valid = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the port not granted last wins; a lone requester always wins.
  assign gnt = (req0 & req1) ? ~last : req1;
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt         = req1 & ~req0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 32Kx16 RAM with one-cycle read latency.
// ARB_ROUND_ROBIN_EN enables the last-grant register and round-robin contention.
//
// state   | meaning
// IDLE    | sample req0/req1, latch winner's we/addr/wdata
// ISSUE   | RAM sees registered addr/we this cycle only
// RD_WAIT | ram_rdata valid, captured into owner's rdata
// ACK     | one-cycle ack to owner
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  import mem_arb_pkg::*;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                sel_gnt;
  logic                sel_valid;
  logic                sel_last;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign sel_last = last_q;
`else
  assign sel_last = 1'b1;
`endif

  arb_select2 u_sel (
    .req0  (req0),
    .req1  (req1),
    .last  (sel_last),
    .gnt   (sel_gnt),
    .valid (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_d     = sel_gnt;
          ram_we_d    = sel_gnt ? we1    : we0;
          ram_addr_d  = sel_gnt ? addr1  : addr0;
          ram_wdata_d = sel_gnt ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = sel_gnt;
`endif
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // ram_we_q still holds the transaction direction during ISSUE.
        ram_we_d = 1'b0;
        state_d  = ram_we_q ? ACK : RD_WAIT;
      end
      RD_WAIT: begin
        if (owner_q) rdata1_d = ram_rdata;
        else         rdata0_d = ram_rdata;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  assign ack0      = (state_q == ACK) && !owner_q;
  assign ack1      = (state_q == ACK) &&  owner_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clock, reset_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          busy, owner;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] rd0_exp, rd1_exp;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  mem_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] ram_mem [0:32767];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // Entered at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_txn(input vec_t v);
    int   lat;
    logic got;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(posedge clock); #1;
    chk("issue_busy", busy, 1);
    chk("issue_owner", owner, v.port);
    chk("issue_we", ram_we, v.we);
    chk("issue_addr", ram_addr, v.addr);
    if (v.we) chk("issue_wdata", ram_wdata, v.wdata);
    chk("issue_no_ack", {ack1, ack0}, 0);
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clock); #1;
      lat++;
      chk("we_outside_issue", ram_we, 0);
      if (ack0 | ack1) got = 1'b1;
    end
    chk("ack_latency", lat, v.we ? 2 : 3);
    chk("ack_port", {ack1, ack0}, v.port ? 2'b10 : 2'b01);
    if (!v.we) begin
      if (v.port) rd1_exp = v.exp_rd;
      else        rd0_exp = v.exp_rd;
    end
    chk("rdata0", rdata0, rd0_exp);
    chk("rdata1", rdata1, rd1_exp);
    drive(v.port, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
    chk("ack_one_cycle", {ack1, ack0}, 0);
    chk("busy_fall", busy, 0);
  endtask

  vec_t vecs [9];
  vec_t v;
  int   n_ack, cyc, last_cyc;
  logic exp_p;

  initial begin
    vecs[0] = '{port:1'b0, we:1'b1, addr:15'h0010, wdata:16'hBEEF, exp_rd:16'h0000};
    vecs[1] = '{port:1'b0, we:1'b0, addr:15'h0010, wdata:16'h0000, exp_rd:16'hBEEF};
    vecs[2] = '{port:1'b1, we:1'b1, addr:15'h7FFF, wdata:16'h1234, exp_rd:16'h0000};
    vecs[3] = '{port:1'b1, we:1'b0, addr:15'h7FFF, wdata:16'h0000, exp_rd:16'h1234};
    vecs[4] = '{port:1'b0, we:1'b1, addr:15'h0000, wdata:16'hFFFF, exp_rd:16'h0000};
    vecs[5] = '{port:1'b0, we:1'b0, addr:15'h0000, wdata:16'h0000, exp_rd:16'hFFFF};
    vecs[6] = '{port:1'b1, we:1'b1, addr:15'h0010, wdata:16'hA5A5, exp_rd:16'h0000};
    vecs[7] = '{port:1'b0, we:1'b0, addr:15'h0010, wdata:16'h0000, exp_rd:16'hA5A5};
    vecs[8] = '{port:1'b1, we:1'b0, addr:15'h0000, wdata:16'h0000, exp_rd:16'hFFFF};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    rd0_exp = '0;
    rd1_exp = '0;
    #3;
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_we_busy_owner", {ram_we, busy, owner}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Known zero at 0x0005 so the aborted read below cannot alter rdata0 either way.
    v = '{port:1'b0, we:1'b1, addr:15'h0005, wdata:16'h0000, exp_rd:16'h0000};
    run_txn(v);

    // Reset during ISSUE of a write: ram_we must drop immediately.
    drive(1'b1, 1'b1, 1'b1, 15'h0006, 16'h7777);
    @(posedge clock); #1;
    chk("rstw_we_before", ram_we, 1);
    reset_n = 1'b0;
    #1;
    chk("rstw_we_after", ram_we, 0);
    chk("rstw_busy", busy, 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("rstw_no_ack", {ack1, ack0, busy}, 0);
    end

    // Reset during RD_WAIT of a read.
    drive(1'b0, 1'b1, 1'b0, 15'h0005, 16'h0000);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rstr_busy_before", busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstr_busy_after", busy, 0);
    chk("rstr_we", ram_we, 0);
    chk("rstr_rdata0", rdata0, 0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("rstr_no_ack", {ack1, ack0, busy}, 0);
    end

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Contention: both ports read continuously, then port 0 backs off.
    drive(1'b0, 1'b1, 1'b0, 15'h0000, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 15'h7FFF, 16'h0000);
    n_ack = 0;
    cyc = 0;
    last_cyc = 0;
    while (n_ack < 7 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0 | ack1) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_p = (n_ack < 6) ? n_ack[0] : 1'b1;
`else
        exp_p = (n_ack < 6) ? 1'b0 : 1'b1;
`endif
        chk("cont_port", {ack1, ack0}, exp_p ? 2'b10 : 2'b01);
        if (n_ack > 0) chk("cont_gap", cyc - last_cyc, 4);
        if (exp_p) rd1_exp = 16'h1234;
        else       rd0_exp = 16'hFFFF;
        chk("cont_rdata0", rdata0, rd0_exp);
        chk("cont_rdata1", rdata1, rd1_exp);
        last_cyc = cyc;
        n_ack++;
        if (n_ack == 6) req0 = 1'b0;
        if (n_ack == 7) req1 = 1'b0;
      end
    end
    chk("cont_ack_count", n_ack, 7);
    @(posedge clock); #1;
    chk("cont_idle", busy, 0);

    // Port 1 drops req and scrambles its inputs during ISSUE of a write.
    drive(1'b1, 1'b1, 1'b1, 15'h0123, 16'h5555);
    @(posedge clock); #1;
    chk("drop_we", ram_we, 1);
    chk("drop_addr", ram_addr, 15'h0123);
    drive(1'b1, 1'b0, 1'b0, 15'h0456, 16'h0000);
    @(posedge clock); #1;
    chk("drop_ack1", {ack1, ack0}, 2'b10);
    chk("drop_addr_hold", ram_addr, 15'h0123);
    chk("drop_wdata_hold", ram_wdata, 16'h5555);
    @(posedge clock); #1;
    chk("drop_idle", busy, 0);
    v = '{port:1'b0, we:1'b0, addr:15'h0123, wdata:16'h0000, exp_rd:16'h5555};
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
